// File: rtl/div8_4_seq_pkg.sv
// Shared definitions for the 8/4 sequential restoring divider.
package div8_4_seq_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  // Divide-by-zero result pattern
  localparam logic [7:0] Q_DZ = 8'hFF;
  localparam logic [3:0] R_DZ = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder, the shared arithmetic building block.
module cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Flattened lookahead carries
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];

endmodule

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the
// shifted partial remainder and keep the difference if it did not borrow.
module div_step (
  input  logic [4:0] i_pr,     // shifted partial remainder
  input  logic [3:0] i_d,      // divisor (non-zero)
  output logic [3:0] o_pr_nxt, // next partial remainder, always < divisor
  output logic       o_qbit
);

  logic [3:0] w_diff;
  logic       w_cout;

  // pr[3:0] - d as pr[3:0] + ~d + 1
  cla4 u_cla (
    .i_a    (i_pr[3:0]),
    .i_b    (~i_d),
    .i_cin  (1'b1),
    .o_sum  (w_diff),
    .o_cout (w_cout)
  );

  // A set bit 4 means pr >= 16 > d, so the subtract can never borrow then.
  // The kept difference is below d, so its bit 4 is always zero.
  assign o_qbit   = w_cout | i_pr[4];
  assign o_pr_nxt = o_qbit ? w_diff : i_pr[3:0];

endmodule

// File: rtl/div8_4_seq.sv
// Sequential restoring divider: one quotient bit per clock with a
// START / BUSY / DONE handshake. DONE is a registered decode of FIN, so it
// rises the cycle after FIN is entered.
module div8_4_seq
  import div8_4_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF   // the CLA step is fixed at 4 bits
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_a,
  input  logic [VW-1:0] i_b,
  output logic          o_busy,
  output logic          o_done,
  output logic [DW-1:0] o_q,
  output logic [VW-1:0] o_r,
  output logic          o_dz
);

  localparam int CW = $clog2(DW + 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_a;      // dividend shifting out, quotient shifting in
  logic [VW-1:0] r_b;
  logic [VW-1:0] r_pr;     // partial remainder, always < divisor between steps
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_r;
  logic          r_dz;

  logic [VW-1:0] w_pr_nxt;
  logic          w_qbit;
  logic [DW-1:0] w_q_nxt;

  div_step u_step (
    .i_pr     ({r_pr, r_a[DW-1]}),
    .i_d      (r_b),
    .o_pr_nxt (w_pr_nxt),
    .o_qbit   (w_qbit)
  );

  assign w_q_nxt = {r_a[DW-2:0], w_qbit};

  // Control FSM, iteration counter, datapath and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_pr    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_b != '0) begin
              r_a     <= i_a;
              r_b     <= i_b;
              r_pr    <= '0;
              r_cnt   <= CW'(DW);
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_q     <= DW'(Q_DZ);
              r_r     <= VW'(R_DZ);
              r_dz    <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_RUN: begin
          r_pr  <= w_pr_nxt;
          r_a   <= w_q_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_busy  <= 1'b0;
            r_q     <= w_q_nxt;
            r_r     <= w_pr_nxt;
            r_dz    <= 1'b0;
            r_state <= S_FIN;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_q    = r_q;
  assign o_r    = r_r;
  assign o_dz   = r_dz;

endmodule
